// File: rtl/qupls_backout_free_queue.sv
// qupls_backout_free_queue
// Sits behind the RAT backout machine during a branch mispredict recovery.
// Each backout write becomes one registered RAT restore write. The discarded
// new mapping from the same write goes into a small FIFO. That FIFO drains to
// the physical register free list over a valid/ready handshake.

module qupls_backout_free_queue #(
  parameter int AREG_W = 7,
  parameter int PREG_W = 9,
  parameter int DEPTH  = 16,
  parameter int AFULL  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bo_wr,
  input  logic [AREG_W-1:0]        bo_areg,
  input  logic [PREG_W-1:0]        bo_preg,
  input  logic [PREG_W-1:0]        bo_nreg,
  input  logic                     restore,
  output logic                     rat_wr,
  output logic [AREG_W-1:0]        rat_areg,
  output logic [PREG_W-1:0]        rat_preg,
  output logic                     fl_valid,
  output logic [PREG_W-1:0]        fl_preg,
  input  logic                     fl_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     afull,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // RAT restore path state
  logic                  ratWr_q;
  logic                  ratWr_d;
  logic [AREG_W-1:0]     ratAreg_q;
  logic [PREG_W-1:0]     ratPreg_q;

  // Free queue storage and bookkeeping
  logic [PREG_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]      rdPtr_q;
  logic [PTR_W-1:0]      rdPtr_d;
  logic [PTR_W-1:0]      wrPtr_q;
  logic [PTR_W-1:0]      wrPtr_d;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  afull_q;
  logic                  overflow_q;
  logic                  overflow_d;

  logic                  pushReq;
  logic                  pushEn;
  logic                  popEn;
  logic                  full;
  logic                  empty;

  // A checkpoint restore rewrites the whole RAT, so a backout write that
  // arrives during one is cancelled. Its freed register is still queued.
  always_comb begin
    ratWr_d = bo_wr & ~restore;
  end

  // Register the RAT write. Address and data keep their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ratWr_q   <= 1'b0;
      ratAreg_q <= '0;
      ratPreg_q <= '0;
    end else begin
      ratWr_q <= ratWr_d;
      if (ratWr_d) begin
        ratAreg_q <= bo_areg;
        ratPreg_q <= bo_preg;
      end
    end
  end

  // Queue control. Register 0 is never allocated, so it is never freed.
  // A pop at full frees a slot for a push in the same cycle.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CNT_W'(DEPTH));
    pushReq    = bo_wr & (bo_nreg != '0);
    popEn      = ~empty & fl_ready;
    pushEn     = pushReq & (~full | popEn);
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (pushReq & full & ~popEn);
    if (pushEn) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and status registers. afull is computed from the
  // next-state count so that it lines up with the count output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      afull_q    <= (count_d >= CNT_W'(AFULL));
      overflow_q <= overflow_d;
    end
  end

  // Entry storage. It has no reset because the pointers and count say
  // which entries are live.
  always_ff @(posedge clk) begin
    if (pushEn && !rst) begin
      mem_q[wrPtr_q] <= bo_nreg;
    end
  end

  // Drive the outputs. fl_preg comes straight from the registered storage,
  // with no write bypass, and reads zero while the queue is empty.
  always_comb begin
    rat_wr   = ratWr_q;
    rat_areg = ratAreg_q;
    rat_preg = ratPreg_q;
    fl_valid = ~empty;
    fl_preg  = empty ? '0 : mem_q[rdPtr_q];
    count    = count_q;
    afull    = afull_q;
    overflow = overflow_q;
  end

endmodule
